// File: rtl/alucontrol_md_pkg.sv
// Shared function codes, ALU op codes and mul/div state encoding for alucontrol_md.
package alucontrol_md_pkg;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } md_state_e;

  // MULT, MULTU, DIV, DIVU occupy 0x18..0x1B.
  function automatic logic is_md_func(logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alucontrol_md_if.sv
// EX-stage control bus between the pipeline (master) and alucontrol_md (slave).
interface alucontrol_md_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             valid_in;
  logic [1:0]       alu_op_in;
  logic [5:0]       func;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic [3:0]       alu_op_out;
  logic             hilo_sel;
  logic [WIDTH-1:0] hilo_res;
  logic             stall;
  logic             md_busy;
  logic             unknown_op;

  modport master (
    output valid_in, alu_op_in, func, rs_val, rt_val, flush,
    input  alu_op_out, hilo_sel, hilo_res, stall, md_busy, unknown_op
  );

  modport slave (
    input  valid_in, alu_op_in, func, rs_val, rt_val, flush,
    output alu_op_out, hilo_sel, hilo_res, stall, md_busy, unknown_op
  );
endinterface

// File: rtl/alucontrol_md_muldiv_iter.sv
// Iterative signed/unsigned multiply and restoring divide, BPC result bits per cycle.
module alucontrol_md_muldiv_iter
  import alucontrol_md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_idle,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned Steps = WIDTH / BPC;
  localparam int unsigned CntW  = $clog2(Steps + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  md_state_e          r_state;
  logic [CntW-1:0]    r_count;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;
  logic               r_neg;
  logic               r_rneg;
  logic               r_div0;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH:0]   w_p;
  logic [WIDTH:0]     w_rem;
  logic [WIDTH-1:0]   w_quo;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_acc_hi;
  logic [WIDTH-1:0]   w_acc_lo;

  assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? (-i_a) : i_a;
  assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? (-i_b) : i_b;

  // r_acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    w_p = {1'b0, r_acc};
    for (int i = 0; i < BPC; i++) begin
      if (w_p[0]) w_p[2*WIDTH:WIDTH] = {1'b0, w_p[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
      w_p = w_p >> 1;
    end
    w_rem = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    w_quo = r_acc[WIDTH-1:0];
    for (int i = 0; i < BPC; i++) begin
      w_rem = {w_rem[WIDTH-1:0], w_quo[WIDTH-1]};
      w_quo = {w_quo[WIDTH-2:0], 1'b0};
      if (w_rem >= {1'b0, r_b}) begin
        w_rem    = w_rem - {1'b0, r_b};
        w_quo[0] = 1'b1;
      end
    end
    w_acc_next = r_is_div ? {w_rem[WIDTH-1:0], w_quo} : w_p[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state  <= StRun;
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_is_div <= i_is_div;
            r_neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_rneg   <= i_signed & i_is_div & i_a[WIDTH-1];
            r_div0   <= i_is_div & (i_b == '0);
            if (i_is_div) begin
              r_acc <= {{WIDTH{1'b0}}, w_a_mag};
              r_b   <= w_b_mag;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_b_mag};
              r_b   <= w_a_mag;
            end
          end
        end
        StRun: begin
          if (i_flush) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else begin
            r_acc   <= w_acc_next;
            r_count <= r_count + 1'b1;
            if (r_count == LastCnt) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_count <= '0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_count <= '0;
        end
      endcase
    end
  end

  // Magnitude result plus sign fix-up; divide by zero forces an all-ones quotient.
  assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_acc_lo = r_acc[WIDTH-1:0];
  assign w_prod   = r_neg ? (-r_acc) : r_acc;

  always_comb begin
    if (r_is_div) begin
      o_lo = r_div0 ? {WIDTH{1'b1}} : (r_neg ? (-w_acc_lo) : w_acc_lo);
      o_hi = r_rneg ? (-w_acc_hi) : w_acc_hi;
    end else begin
      o_hi = w_prod[2*WIDTH-1:WIDTH];
      o_lo = w_prod[WIDTH-1:0];
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done & ~i_flush;
  assign o_idle = (r_state == StIdle);

endmodule

// File: rtl/alucontrol_md.sv
// EX-stage ALU control with HI/LO registers, mul/div engine and hazard stall.
// Optional ALUCTRL_MTHILO_EN enables MTHI/MTLO writes into HI/LO.
module alucontrol_md
  import alucontrol_md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input logic           clk,
  input logic           rst_n,
  alucontrol_md_if.slave io_bus
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [3:0]       w_alu_op;
  logic             w_unknown;
  logic             w_is_md;
  logic             w_is_mf;
  logic             w_is_mfhi;
  logic             w_is_mthi;
  logic             w_is_mtlo;
  logic             w_start;
  logic             w_busy;
  logic             w_done;
  logic             w_idle;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;

  always_comb begin
    w_alu_op  = OP_ADD;
    w_unknown = 1'b0;
    w_is_md   = 1'b0;
    w_is_mf   = 1'b0;
    w_is_mfhi = 1'b0;
    w_is_mthi = 1'b0;
    w_is_mtlo = 1'b0;
    unique case (io_bus.alu_op_in)
      2'b00: w_alu_op = OP_ADD;
      2'b01: w_alu_op = OP_SUB;
      2'b10: begin
        case (io_bus.func)
          FN_SLL:  w_alu_op = OP_SLL;
          FN_SRL:  w_alu_op = OP_SRL;
          FN_SRA:  w_alu_op = OP_SRA;
          FN_ADD:  w_alu_op = OP_ADD;
          FN_SUB:  w_alu_op = OP_SUB;
          FN_AND:  w_alu_op = OP_AND;
          FN_OR:   w_alu_op = OP_OR;
          FN_XOR:  w_alu_op = OP_XOR;
          FN_NOR:  w_alu_op = OP_NOR;
          FN_SLT:  w_alu_op = OP_SLT;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: w_is_md = is_md_func(io_bus.func);
          FN_MFHI: begin
            w_is_mf   = 1'b1;
            w_is_mfhi = 1'b1;
          end
          FN_MFLO: w_is_mf = 1'b1;
`ifdef ALUCTRL_MTHILO_EN
          FN_MTHI: w_is_mthi = 1'b1;
          FN_MTLO: w_is_mtlo = 1'b1;
`else
          FN_MTHI, FN_MTLO: w_unknown = 1'b1;
`endif
          default: w_unknown = 1'b1;
        endcase
      end
      default: w_unknown = 1'b1;
    endcase
  end

  // Ops touching HI/LO wait out the engine; the accepting mul/div itself never stalls.
  assign w_start = io_bus.valid_in & ~io_bus.flush & w_idle & w_is_md;

  assign io_bus.alu_op_out = w_alu_op;
  assign io_bus.unknown_op = io_bus.valid_in & w_unknown;
  assign io_bus.hilo_sel   = io_bus.valid_in & w_is_mf;
  assign io_bus.hilo_res   = w_is_mfhi ? r_hi : r_lo;
  assign io_bus.md_busy    = w_busy;
  assign io_bus.stall      = io_bus.valid_in & ~w_idle &
                             (w_is_md | w_is_mf | w_is_mthi | w_is_mtlo);

  alucontrol_md_muldiv_iter #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_flush  (io_bus.flush),
    .i_is_div (io_bus.func[1]),
    .i_signed (~io_bus.func[0]),
    .i_a      (io_bus.rs_val),
    .i_b      (io_bus.rt_val),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_idle   (w_idle),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      r_hi <= w_md_hi;
      r_lo <= w_md_lo;
    end else if (io_bus.valid_in && !io_bus.flush && w_idle) begin
      if (w_is_mthi) r_hi <= io_bus.rs_val;
      if (w_is_mtlo) r_lo <= io_bus.rs_val;
    end
  end

endmodule
